// File: rtl/enemy_pkg.sv
// ----------------------------------------------------------------------------
// enemy_pkg
// Shared definitions for the enemy formation controller:
//   - state_e : formation sequencer states
//   - dir_e   : horizontal travel direction encoding
//   - X_MAX   : right screen bound (exclusive), in pixels
//   - Y_LIMIT : formation bottom at or past this row means the wave is lost
// ----------------------------------------------------------------------------
package enemy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MOVE = 3'd1,
        ST_DROP = 3'd2,
        ST_WON  = 3'd3,
        ST_LOST = 3'd4
    } state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    localparam int X_MAX   = 640;
    localparam int Y_LIMIT = 448;

endpackage

// File: rtl/enemy_step_timer.sv
// ----------------------------------------------------------------------------
// enemy_step_timer
// Frame counter that decides when the formation takes its next step.
// Configuration macro: ENEMY_SPEEDUP_EN
//   defined     : period = MIN_PERIOD + popcount(alive)
//   not defined : period = BASE_PERIOD
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : clear the counter (wave load)
//   count_en    : count frame ticks (formation is moving)
//   frame_tick  : one pulse per VGA frame
//   alive       : per-enemy alive mask (period source in speed-up mode)
//   step        : one-cycle pulse on the tick that completes a period
// ----------------------------------------------------------------------------
module enemy_step_timer
    import enemy_pkg::*;
#(
    parameter int N_ENEMIES   = 8,
    parameter int BASE_PERIOD = 30,
    parameter int MIN_PERIOD  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 count_en,
    input  logic                 frame_tick,
    input  logic [N_ENEMIES-1:0] alive,
    output logic                 step
);

`ifdef ENEMY_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] alive_cnt;
    logic [7:0] period;
    logic [7:0] period_m1;

    always_comb begin
        alive_cnt = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            alive_cnt = alive_cnt + 8'(alive[i]);
        end
    end

    // Fewer survivors means a shorter period, so the formation speeds up.
    assign period    = SPEEDUP ? 8'(MIN_PERIOD) + alive_cnt : 8'(BASE_PERIOD);
    assign period_m1 = period - 8'd1;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && frame_tick) begin
            // ">=" rather than "==": the period can shrink below a count
            // already reached, and that tick must still step.
            if (cnt_q >= period_m1) begin
                step  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; blocking
    // assignments here would make results depend on process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/enemy_formation_ctrl.sv
// ----------------------------------------------------------------------------
// enemy_formation_ctrl
// Sequences the invaders formation: owns the shared formation origin, steps
// it once per movement period, drops and reverses at the screen edges,
// toggles the walk animation, tracks alive enemies and reports won/lost.
// Configuration macro: ENEMY_SPEEDUP_EN (period shrinks as enemies die,
// handled inside enemy_step_timer).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   frame_tick  : one pulse per VGA frame
//   start       : load and start a wave (ignored while the wave runs)
//   hit         : per-enemy one-cycle collision pulse
//   form_x/y    : formation origin in pixels
//   anim        : walk-animation frame select
//   alive       : per-enemy alive mask
//   busy        : formation moving or dropping
//   won / lost  : wave outcome
// ----------------------------------------------------------------------------
module enemy_formation_ctrl
    import enemy_pkg::*;
#(
    parameter int N_ENEMIES   = 8,
    parameter int FORM_W      = 184,
    parameter int FORM_H      = 16,
    parameter int X_START     = 16,
    parameter int Y_START     = 32,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int X_MIN       = 0,
    parameter int BASE_PERIOD = 30,
    parameter int MIN_PERIOD  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic [N_ENEMIES-1:0] hit,
    output logic [9:0]           form_x,
    output logic [9:0]           form_y,
    output logic                 anim,
    output logic [N_ENEMIES-1:0] alive,
    output logic                 busy,
    output logic                 won,
    output logic                 lost
);

    state_e                 state_q, state_d;
    dir_e                   dir_q, dir_d;
    logic [9:0]             form_x_q, form_x_d;
    logic [9:0]             form_y_q, form_y_d;
    logic                   anim_q, anim_d;
    logic [N_ENEMIES-1:0]   alive_q, alive_d;
    logic                   busy_q, busy_d;
    logic                   won_q, won_d;
    logic                   lost_q, lost_d;

    logic                   load;
    logic                   step;
    logic                   at_edge;
    logic [9:0]             y_next;

    enemy_step_timer #(
        .N_ENEMIES   (N_ENEMIES),
        .BASE_PERIOD (BASE_PERIOD),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load),
        .count_en   (state_q == ST_MOVE),
        .frame_tick (frame_tick),
        .alive      (alive_q),
        .step       (step)
    );

    assign load = start && (state_q == ST_IDLE || state_q == ST_WON ||
                            state_q == ST_LOST);

    // Edge tests run at 11 bits so FORM_W + STEP_X cannot wrap past 1023.
    always_comb begin
        if (dir_q == DIR_RIGHT) begin
            at_edge = ({1'b0, form_x_q} + 11'(FORM_W) + 11'(STEP_X)) > 11'(X_MAX);
        end else begin
            at_edge = {1'b0, form_x_q} < 11'(X_MIN + STEP_X);
        end
    end

    assign y_next = form_y_q + 10'(STEP_Y);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        form_x_d = form_x_q;
        form_y_d = form_y_q;
        anim_d   = anim_q;
        alive_d  = alive_q;

        case (state_q)
            ST_MOVE: begin
                alive_d = alive_q & ~hit;
                // An empty formation wins before any edge handling.
                if (alive_q == '0) begin
                    state_d = ST_WON;
                end else if (step) begin
                    anim_d = ~anim_q;
                    if (at_edge) begin
                        state_d = ST_DROP;
                    end else if (dir_q == DIR_RIGHT) begin
                        form_x_d = form_x_q + 10'(STEP_X);
                    end else begin
                        form_x_d = form_x_q - 10'(STEP_X);
                    end
                end
            end

            ST_DROP: begin
                alive_d = alive_q & ~hit;
                if (alive_q == '0) begin
                    state_d = ST_WON;
                end else begin
                    form_y_d = y_next;
                    dir_d    = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                    if (({1'b0, y_next} + 11'(FORM_H)) >= 11'(Y_LIMIT)) begin
                        state_d = ST_LOST;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end
            end

            default: begin
                // IDLE, WON and LOST hold everything until a new wave loads.
                if (load) begin
                    state_d  = ST_MOVE;
                    dir_d    = DIR_RIGHT;
                    form_x_d = 10'(X_START);
                    form_y_d = 10'(Y_START);
                    anim_d   = 1'b0;
                    alive_d  = '1;
                end
            end
        endcase

        busy_d = (state_d == ST_MOVE) || (state_d == ST_DROP);
        won_d  = (state_d == ST_WON);
        lost_d = (state_d == ST_LOST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_RIGHT;
            form_x_q <= 10'(X_START);
            form_y_q <= 10'(Y_START);
            anim_q   <= 1'b0;
            alive_q  <= '0;
            busy_q   <= 1'b0;
            won_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            form_x_q <= form_x_d;
            form_y_q <= form_y_d;
            anim_q   <= anim_d;
            alive_q  <= alive_d;
            busy_q   <= busy_d;
            won_q    <= won_d;
            lost_q   <= lost_d;
        end
    end

    assign form_x = form_x_q;
    assign form_y = form_y_q;
    assign anim   = anim_q;
    assign alive  = alive_q;
    assign busy   = busy_q;
    assign won    = won_q;
    assign lost   = lost_q;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// ----------------------------------------------------------------------------
// tb_enemy_formation_ctrl
// Table-driven bench for enemy_formation_ctrl. Each table row holds the
// inputs to apply, how many consecutive cycles to apply them, and the
// outputs expected one edge after the last of those cycles. A second
// instance with a wide formation and a one-frame period reaches the
// LOST condition quickly.
// ----------------------------------------------------------------------------
module tb_enemy_formation_ctrl;

`ifdef ENEMY_SPEEDUP_EN
    localparam int P = 12;   // MIN_PERIOD 4 + 8 alive
`else
    localparam int P = 30;   // BASE_PERIOD
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       anim;
        logic [7:0] alive;
        logic       busy;
        logic       won;
        logic       lost;
    } out_t;

    typedef struct {
        string      name;
        int         rep;
        logic       rst;
        logic       start;
        logic       tick;
        logic [7:0] hit;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, start;
    logic [7:0] hit;
    logic [9:0] form_x, form_y;
    logic       anim, busy, won, lost;
    logic [7:0] alive;

    logic       f_tick, f_start;
    logic [7:0] f_hit;
    logic [9:0] f_form_x, f_form_y;
    logic       f_anim, f_busy, f_won, f_lost;
    logic [7:0] f_alive;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    enemy_formation_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .hit        (hit),
        .form_x     (form_x),
        .form_y     (form_y),
        .anim       (anim),
        .alive      (alive),
        .busy       (busy),
        .won        (won),
        .lost       (lost)
    );

    enemy_formation_ctrl #(
        .FORM_W      (600),
        .BASE_PERIOD (1),
        .MIN_PERIOD  (1)
    ) dut_fast (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (f_tick),
        .start      (f_start),
        .hit        (f_hit),
        .form_x     (f_form_x),
        .form_y     (f_form_y),
        .anim       (f_anim),
        .alive      (f_alive),
        .busy       (f_busy),
        .won        (f_won),
        .lost       (f_lost)
    );

    function automatic out_t o(input int x, input int y, input logic a,
                               input logic [7:0] al, input logic b,
                               input logic w, input logic l);
        out_t r;
        r.x = 10'(x); r.y = 10'(y); r.anim = a; r.alive = al;
        r.busy = b; r.won = w; r.lost = l;
        return r;
    endfunction

    function automatic void add(input string nm, input int rep, input logic rst,
                                input logic st, input logic tk,
                                input logic [7:0] h, input out_t e);
        vec_t v;
        v.name = nm; v.rep = rep; v.rst = rst; v.start = st; v.tick = tk;
        v.hit = h; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d anim=%0b alive=%02h busy=%0b won=%0b lost=%0b | want x=%0d y=%0d anim=%0b alive=%02h busy=%0b won=%0b lost=%0b",
                     nm, got.x, got.y, got.anim, got.alive, got.busy, got.won, got.lost,
                     exp.x, exp.y, exp.anim, exp.alive, exp.busy, exp.won, exp.lost);
        end
    endtask

    function automatic out_t main_out();
        return {form_x, form_y, anim, alive, busy, won, lost};
    endfunction

    function automatic out_t fast_out();
        return {f_form_x, f_form_y, f_anim, f_alive, f_busy, f_won, f_lost};
    endfunction

    initial begin
        out_t rst_o, ld_o, lost_o;
        bit   seen_lost;

        rst_o  = o(16, 32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        ld_o   = o(16, 32, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        // Wide formation: 7 toggles on the first row, 11 on each of the next
        // 24 rows; the 25th drop happens at the right edge x=40.
        lost_o = o(40, 432, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);

        // ---------------- common sequence ----------------
        add("reset_state",   1,     0, 0, 0, 8'h00, rst_o);
        add("idle_ticks",    5,     0, 0, 1, 8'h00, rst_o);
        add("start_load",    1,     0, 1, 0, 8'h00, ld_o);
        add("short_period",  P - 1, 0, 0, 1, 8'h00, ld_o);
        add("first_step",    1,     0, 0, 1, 8'h00, o(20, 32, 1, 8'hFF, 1, 0, 0));
        add("start_ignored", 1,     0, 1, 0, 8'h00, o(20, 32, 1, 8'hFF, 1, 0, 0));
        add("run_to_456",    P*109, 0, 0, 1, 8'h00, o(456, 32, 0, 8'hFF, 1, 0, 0));
        add("edge_to_drop",  P,     0, 0, 1, 8'h00, o(456, 32, 1, 8'hFF, 1, 0, 0));
        add("drop_y",        1,     0, 0, 0, 8'h00, o(456, 48, 1, 8'hFF, 1, 0, 0));
        add("step_left",     P,     0, 0, 1, 8'h00, o(452, 48, 0, 8'hFF, 1, 0, 0));
        add("run_to_100",    P*88,  0, 0, 1, 8'h00, o(100, 48, 0, 8'hFF, 1, 0, 0));
        add("mid_reset",     1,     1, 0, 0, 8'h00, rst_o);
        add("ticks_after_rst", 40,  0, 0, 1, 8'h00, rst_o);
        add("restart",       1,     0, 1, 0, 8'h00, ld_o);
`ifdef ENEMY_SPEEDUP_EN
        add("sp_short",      11,    0, 0, 1, 8'h00, ld_o);
        add("sp_step12",     1,     0, 0, 1, 8'h00, o(20, 32, 1, 8'hFF, 1, 0, 0));
        add("sp_hit2_tick",  1,     0, 0, 1, 8'h03, o(20, 32, 1, 8'hFC, 1, 0, 0));
        add("sp_short10",    8,     0, 0, 1, 8'h00, o(20, 32, 1, 8'hFC, 1, 0, 0));
        add("sp_step10",     1,     0, 0, 1, 8'h00, o(24, 32, 0, 8'hFC, 1, 0, 0));
        add("sp_cnt9",       9,     0, 0, 1, 8'h00, o(24, 32, 0, 8'hFC, 1, 0, 0));
        add("sp_hit4",       1,     0, 0, 0, 8'h3C, o(24, 32, 0, 8'hC0, 1, 0, 0));
        add("sp_overrun",    1,     0, 0, 1, 8'h00, o(28, 32, 1, 8'hC0, 1, 0, 0));
        add("sp_dead_hit",   1,     0, 0, 0, 8'h03, o(28, 32, 1, 8'hC0, 1, 0, 0));
        add("sp_last_hit",   1,     0, 0, 0, 8'hC0, o(28, 32, 1, 8'h00, 1, 0, 0));
        add("sp_won",        1,     0, 0, 0, 8'h00, o(28, 32, 1, 8'h00, 0, 1, 0));
        add("sp_won_frozen", 40,    0, 0, 1, 8'hFF, o(28, 32, 1, 8'h00, 0, 1, 0));
`else
        add("fx_step",       P,     0, 0, 1, 8'h00, o(20, 32, 1, 8'hFF, 1, 0, 0));
        add("fx_hit2_tick",  1,     0, 0, 1, 8'h03, o(20, 32, 1, 8'hFC, 1, 0, 0));
        add("fx_short",      P - 2, 0, 0, 1, 8'h00, o(20, 32, 1, 8'hFC, 1, 0, 0));
        add("fx_tick_counted", 1,   0, 0, 1, 8'h00, o(24, 32, 0, 8'hFC, 1, 0, 0));
        add("fx_dead_hit",   1,     0, 0, 0, 8'h03, o(24, 32, 0, 8'hFC, 1, 0, 0));
        add("fx_hit4",       1,     0, 0, 0, 8'hF0, o(24, 32, 0, 8'h0C, 1, 0, 0));
        add("fx_last_hit",   1,     0, 0, 0, 8'h0C, o(24, 32, 0, 8'h00, 1, 0, 0));
        add("fx_won",        1,     0, 0, 0, 8'h00, o(24, 32, 0, 8'h00, 0, 1, 0));
        add("fx_won_frozen", 40,    0, 0, 1, 8'hFF, o(24, 32, 0, 8'h00, 0, 1, 0));
`endif
        add("restart_won",   1,     0, 1, 0, 8'h00, ld_o);

        // ---------------- reset ----------------
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; hit = '0;
        f_tick = 1'b0; f_start = 1'b0; f_hit = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].rep; k++) begin
                reset      = vecs[i].rst;
                start      = vecs[i].start;
                frame_tick = vecs[i].tick;
                hit        = vecs[i].hit;
                @(posedge clk);
                #1;
            end
            reset = 1'b0; start = 1'b0; frame_tick = 1'b0; hit = '0;
            check(vecs[i].name, main_out(), vecs[i].exp);
        end

        // ---------------- drop until LOST (wide formation) ----------------
        f_start = 1'b1;
        @(posedge clk);
        #1;
        f_start = 1'b0;
        check("fast_start", fast_out(), ld_o);

        seen_lost = 1'b0;
        f_tick    = 1'b1;
        for (int c = 0; c < 10000 && !seen_lost; c++) begin
            @(posedge clk);
            #1;
            // LOST must appear exactly when the origin reaches row 432.
            if (f_lost || f_form_y == 10'd432) seen_lost = 1'b1;
        end
        f_tick = 1'b0;
        if (!seen_lost) begin
            $display("FAIL fast_lost_timeout: got no LOST within 10000 cycles, want lost=1");
            n_vec++;
            n_err++;
        end else begin
            check("fast_lost", fast_out(), lost_o);
        end

        f_tick = 1'b1; f_hit = 8'h01;
        repeat (20) @(posedge clk);
        #1;
        f_tick = 1'b0; f_hit = '0;
        check("fast_lost_frozen", fast_out(), lost_o);

        f_start = 1'b1;
        @(posedge clk);
        #1;
        f_start = 1'b0;
        check("fast_restart", fast_out(), ld_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enemy_formation_ctrl.md
# enemy_formation_ctrl

Sequences the enemy formation for the invaders game. Owns the shared formation origin that every enemy sprite instance renders from, steps it horizontally once per movement period, drops and reverses it at the screen edges, and toggles the two-frame walk animation. Tracks which enemies are alive from per-enemy collision pulses and reports wave won or lost to the game top level. Sits between the VGA frame timing and the array of enemy sprite/collision instances.

## Interface
- N_ENEMIES, 8, number of enemy instances; width of `alive` and `hit`
- FORM_W, 184, formation width in pixels
- FORM_H, 16, formation height in pixels
- X_START, 16, origin X loaded on start
- Y_START, 32, origin Y loaded on start
- STEP_X, 4, horizontal pixels per step
- STEP_Y, 16, pixels per drop
- X_MIN, 0, left bound
- X_MAX, 640, right bound (exclusive)
- Y_LIMIT, 448, formation bottom at or past this means lost
- BASE_PERIOD, 30, frames per step (fixed mode)
- MIN_PERIOD, 4, minimum frames per step (speed-up mode)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per VGA frame
- start  in  1  one-cycle pulse to load and start a wave
- hit  in  N_ENEMIES  one-cycle collision pulse per enemy
- form_x  out  10  formation origin X
- form_y  out  10  formation origin Y
- anim  out  1  walk-animation frame select to all sprites
- alive  out  N_ENEMIES  per-enemy alive mask
- busy  out  1  high in MOVE or DROP
- won  out  1  high in WON
- lost  out  1  high in LOST

## Operation
- States: IDLE, MOVE, DROP, WON, LOST. All outputs registered.
- Reset: state IDLE, form_x=X_START, form_y=Y_START, anim=0, alive=0, direction right, frame counter 0, busy/won/lost=0.
- `start` in IDLE, WON or LOST: load X_START/Y_START, alive all ones, direction right, counter 0, anim 0, go to MOVE. Ignored in MOVE and DROP.
- MOVE: each `frame_tick` increments the counter. When the counter reaches period−1 on a tick, that is a step event: the counter clears and anim toggles.
  - Moving right with form_x+FORM_W+STEP_X > X_MAX, or moving left with form_x < X_MIN+STEP_X: go to DROP and leave form_x unchanged.
  - Otherwise form_x ± STEP_X.
- DROP (one cycle): form_y += STEP_Y, direction flips. Then go to LOST if the new form_y+FORM_H ≥ Y_LIMIT, otherwise back to MOVE.
- `hit[i]` clears alive[i] in MOVE and DROP. It is ignored in IDLE, WON and LOST, and ignored on an enemy that is already dead. Several hits in one cycle all apply.
- If alive becomes 0, go to WON on the next cycle. WON has priority over a simultaneous MOVE→DROP or DROP→LOST transition.
- In WON and LOST, form_x, form_y, anim and alive are frozen.
- Arithmetic is 10-bit unsigned. Comparisons are evaluated at 11 bits so that FORM_W+STEP_X cannot wrap. Counter and period are 8 bits.

## Timing
- A step or animation toggle is visible one cycle after the frame_tick that completes the period.
- A drop is visible two cycles after its step event: one cycle to enter DROP, one to update form_y.
- alive[i] clears one cycle after hit[i]. won asserts two cycles after the last hit.
- reset asserted mid-wave returns all outputs to their reset values on the next edge.
- A frame_tick coinciding with a hit still counts.

## Configuration
- ENEMY_SPEEDUP_EN defined: period = MIN_PERIOD + popcount(alive). The new value takes effect at the next counter comparison. If the counter already exceeds period−1, the next tick is a step event.
- Not defined: period = BASE_PERIOD, regardless of alive.

## Structure
- Shared package `enemy_pkg` holds the state enum, the screen constants (X_MAX, Y_LIMIT) and the direction encoding.
- Sub-module `enemy_step_timer` holds the frame counter and period computation, including the popcount under ENEMY_SPEEDUP_EN. It emits a one-cycle `step` pulse.

## Test plan
- Defaults, fixed mode: start, then 30 frame_ticks → form_x 16→20 and anim=1 one cycle after the 30th tick. 29 ticks → no change.
- Right edge: run to form_x=456, then one more step event → DROP, form_y 32→48, form_x stays 456, next step form_x=452.
- ENEMY_SPEEDUP_EN with 8 alive: step every 12 ticks. After hit[0] and hit[1] in the same cycle: alive=0xFC and step every 10 ticks.
- All 8 hits → alive=0 then won=1, busy=0. Further hits and ticks → no change. start → alive=0xFF, form_x=16, MOVE.
- Drop until form_y=432 → lost=1 after that DROP, outputs frozen. A hit in LOST leaves alive unchanged.
- reset pulse mid-MOVE at form_x=100 → next cycle form_x=16, alive=0, state IDLE. frame_ticks then do nothing until start.
